// File: rtl/muldiv_if.sv
// muldiv_if: request/write-back bundle between the core and muldiv_unit.
//   master (core side) drives start, op, rs1_data, rs2_data, rd_addr_in, kill
//                      and observes busy, done, wr_en, wr_addr, wr_data.
//   slave  (unit side) is the mirror image.
interface muldiv_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [4:0]            rd_addr_in;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr_in, kill,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr_in, kill,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Radix-2 shift-add multiply and restoring divide on operand magnitudes, one bit per
//   cycle, so every op takes DATA_WIDTH iterations plus a DONE cycle. The result is
//   presented as a one-cycle register-file write-back pulse.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_if.slave: start/op/rs1_data/rs2_data/rd_addr_in/kill in,
//          busy/done/wr_en/wr_addr/wr_data out
// Build option:
//   MULDIV_DIV_EN - when defined, the divide path is built. When undefined, ops 100..111
//                   complete in one cycle with wr_data = 0.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(W);

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

  state_e          state_q;
  logic [1:0]      op_q;      // op[2] is only needed to pick the state
  logic            neg_q;     // negate the final magnitude
  logic [4:0]      rd_q;
  logic [CntW-1:0] cnt_q;
  logic [2*W-1:0]  acc_q;     // mul: {partial product, multiplier}; div: {rem, dividend/quotient}
  logic [W-1:0]    mcand_q;   // mul: multiplicand magnitude; div: divisor magnitude
  logic            busy_q;
  logic            done_q;
  logic            wr_en_q;
  logic [4:0]      wr_addr_q;
  logic [W-1:0]    wr_data_q;

  // Operand sign handling at accept time.
  logic         a_neg, b_neg, res_neg;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_neg = bus.rs1_data[W-1];
        b_neg = bus.rs2_data[W-1];
      end
      3'b010:  a_neg = bus.rs1_data[W-1];
      default: ;
    endcase
    a_mag   = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag   = b_neg ? -bus.rs2_data : bus.rs2_data;
    // Remainder follows the dividend; everything else is sign(A) xor sign(B).
    res_neg = (bus.op == 3'b110) ? a_neg : (a_neg ^ b_neg);
  end

  // One shift-add step; the carry out of the add becomes the new top bit.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_acc;
  logic [2*W-1:0] mul_prod;
  logic [W-1:0]   mul_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    mul_acc  = {mul_sum, acc_q[W-1:1]};
    mul_prod = neg_q ? -mul_acc : mul_acc;
    mul_res  = (op_q == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
  end

`ifdef MULDIV_DIV_EN
  logic           div0_q;
  logic [W:0]     div_shift;
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_acc;
  logic [W-1:0]   div_val;
  logic [W-1:0]   div_res;

  // Restoring step. With a zero divisor every trial succeeds, so the remainder ends up as
  // |A| and its sign as sign(A), which already yields REM = A. Only the quotient needs an
  // override. The signed-overflow case also falls out naturally (|A|/1, positive sign).
  always_comb begin
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    div_acc   = div_trial[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    div_val   = op_q[1] ? div_acc[2*W-1:W] : div_acc[W-1:0];
    if (div0_q && !op_q[1]) begin
      div_res = '1;
    end else begin
      div_res = neg_q ? -div_val : div_val;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rd_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef MULDIV_DIV_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.kill) begin
            op_q   <= bus.op[1:0];
            rd_q   <= bus.rd_addr_in;
            neg_q  <= res_neg;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (!bus.op[2]) begin
              state_q <= StMul;
              acc_q   <= {{W{1'b0}}, b_mag};
              mcand_q <= a_mag;
            end else begin
`ifdef MULDIV_DIV_EN
              state_q <= StDiv;
              acc_q   <= {{W{1'b0}}, a_mag};
              mcand_q <= b_mag;
              div0_q  <= (bus.rs2_data == '0);
`else
              state_q   <= StDone;
              done_q    <= 1'b1;
              wr_en_q   <= (bus.rd_addr_in != 5'd0);
              wr_addr_q <= bus.rd_addr_in;
              wr_data_q <= '0;
`endif
            end
          end
        end
        StMul: begin
          if (bus.kill) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= mul_acc;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
              state_q   <= StDone;
              done_q    <= 1'b1;
              wr_en_q   <= (rd_q != 5'd0);
              wr_addr_q <= rd_q;
              wr_data_q <= mul_res;
            end
          end
        end
`ifdef MULDIV_DIV_EN
        StDiv: begin
          if (bus.kill) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= div_acc;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
              state_q   <= StDone;
              done_q    <= 1'b1;
              wr_en_q   <= (rd_q != 5'd0);
              wr_addr_q <= rd_q;
              wr_data_q <= div_res;
            end
          end
        end
`endif
        StDone: begin
          // kill here has the same effect as normal completion; only the pulse is masked.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q & ~bus.kill;
  assign bus.wr_en   = wr_en_q & ~bus.kill;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
